// File: rtl/fp_align_shifter.sv
// Pre-normalization alignment for binary32 add/sub: orders two operands by magnitude
// and right-shifts the smaller significand onto the larger exponent, with guard/round/sticky.
module fp_align_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exponent_out,
    output logic [23:0] significand_large,
    output logic [23:0] significand_small,
    output logic        guard_bit,
    output logic        round_bit,
    output logic        sticky_bit,
    output logic        sign_large,
    output logic        sign_small,
    output logic        swapped
);

    logic        s1_valid_q;
    logic [7:0]  s1_exp_q;
    logic [23:0] s1_sig_large_q;
    logic [23:0] s1_sig_small_q;
    logic [7:0]  s1_diff_q;
    logic        s1_sign_large_q;
    logic        s1_sign_small_q;
    logic        s1_swapped_q;

    logic        s2_valid_q;
    logic [7:0]  s2_exp_q;
    logic [23:0] s2_sig_large_q;
    logic [23:0] s2_sig_small_q;
    logic        s2_guard_q;
    logic        s2_round_q;
    logic        s2_sticky_q;
    logic        s2_sign_large_q;
    logic        s2_sign_small_q;
    logic        s2_swapped_q;

    logic        s2_advance;
    logic        s1_advance;
    logic        accept;

    logic [7:0]  exp_a_eff;
    logic [7:0]  exp_b_eff;
    logic [23:0] sig_a;
    logic [23:0] sig_b;
    logic        a_is_large;
    logic [7:0]  exp_d;
    logic [23:0] sig_large_d;
    logic [23:0] sig_small_d;
    logic [7:0]  diff_d;
    logic        sign_large_d;
    logic        sign_small_d;
    logic        swapped_d;

    logic [26:0] shift_ext;
    logic [26:0] shift_out;
    logic [26:0] lost_mask;
    logic        lost_bits;
    logic [23:0] shifted_sig_d;
    logic        guard_d;
    logic        round_d;
    logic        sticky_d;

    assign s2_advance = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_advance;
    assign in_ready   = s1_advance;
    assign accept     = in_valid && s1_advance;

    // Zero and denormals share effective exponent 1 so the exponent difference stays exact.
    always_comb begin
        exp_a_eff    = (operand_a[30:23] == 8'd0) ? 8'd1 : operand_a[30:23];
        exp_b_eff    = (operand_b[30:23] == 8'd0) ? 8'd1 : operand_b[30:23];
        sig_a        = {(operand_a[30:23] != 8'd0), operand_a[22:0]};
        sig_b        = {(operand_b[30:23] != 8'd0), operand_b[22:0]};
        a_is_large   = {exp_a_eff, operand_a[22:0]} >= {exp_b_eff, operand_b[22:0]};
        exp_d        = exp_b_eff;
        sig_large_d  = sig_b;
        sig_small_d  = sig_a;
        diff_d       = exp_b_eff - exp_a_eff;
        sign_large_d = operand_b[31];
        sign_small_d = operand_a[31];
        swapped_d    = 1'b1;
        if (a_is_large) begin
            exp_d        = exp_a_eff;
            sig_large_d  = sig_a;
            sig_small_d  = sig_b;
            diff_d       = exp_a_eff - exp_b_eff;
            sign_large_d = operand_a[31];
            sign_small_d = operand_b[31];
            swapped_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_exp_q        <= 8'd0;
            s1_sig_large_q  <= 24'd0;
            s1_sig_small_q  <= 24'd0;
            s1_diff_q       <= 8'd0;
            s1_sign_large_q <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_swapped_q    <= 1'b0;
        end else begin
            if (s1_advance) begin
                s1_valid_q <= in_valid;
            end
            if (accept) begin
                s1_exp_q        <= exp_d;
                s1_sig_large_q  <= sig_large_d;
                s1_sig_small_q  <= sig_small_d;
                s1_diff_q       <= diff_d;
                s1_sign_large_q <= sign_large_d;
                s1_sign_small_q <= sign_small_d;
                s1_swapped_q    <= swapped_d;
            end
        end
    end

    // Past 25 positions every significand bit lands below round, so only sticky survives.
    always_comb begin
        shift_ext = {s1_sig_small_q, 3'b000};
        shift_out = shift_ext >> s1_diff_q;
        lost_mask = (27'd1 << s1_diff_q) - 27'd1;
        lost_bits = |(shift_ext & lost_mask);
        shifted_sig_d = shift_out[26:3];
        guard_d       = shift_out[2];
        round_d       = shift_out[1];
        sticky_d      = shift_out[0] | lost_bits;
        if (s1_diff_q >= 8'd26) begin
            shifted_sig_d = 24'd0;
            guard_d       = 1'b0;
            round_d       = 1'b0;
            sticky_d      = |s1_sig_small_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q      <= 1'b0;
            s2_exp_q        <= 8'd0;
            s2_sig_large_q  <= 24'd0;
            s2_sig_small_q  <= 24'd0;
            s2_guard_q      <= 1'b0;
            s2_round_q      <= 1'b0;
            s2_sticky_q     <= 1'b0;
            s2_sign_large_q <= 1'b0;
            s2_sign_small_q <= 1'b0;
            s2_swapped_q    <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_exp_q        <= s1_exp_q;
                s2_sig_large_q  <= s1_sig_large_q;
                s2_sig_small_q  <= shifted_sig_d;
                s2_guard_q      <= guard_d;
                s2_round_q      <= round_d;
                s2_sticky_q     <= sticky_d;
                s2_sign_large_q <= s1_sign_large_q;
                s2_sign_small_q <= s1_sign_small_q;
                s2_swapped_q    <= s1_swapped_q;
            end
        end
    end

    assign out_valid         = s2_valid_q;
    assign exponent_out      = s2_exp_q;
    assign significand_large = s2_sig_large_q;
    assign significand_small = s2_sig_small_q;
    assign guard_bit         = s2_guard_q;
    assign round_bit         = s2_round_q;
    assign sticky_bit        = s2_sticky_q;
    assign sign_large        = s2_sign_large_q;
    assign sign_small        = s2_sign_small_q;
    assign swapped           = s2_swapped_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Bench for fp_align_shifter: directed alignment cases, backpressure, mid-stall reset,
// plus a random stream checked through a scoreboard against a bit-serial reference model.
module tb_fp_align_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exponent_out;
    logic [23:0] significand_large;
    logic [23:0] significand_small;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        sign_large;
    logic        sign_small;
    logic        swapped;

    logic [61:0] obs;
    logic [61:0] sb[$];
    int          tests = 0;
    int          fails = 0;

    fp_align_shifter dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .exponent_out      (exponent_out),
        .significand_large (significand_large),
        .significand_small (significand_small),
        .guard_bit         (guard_bit),
        .round_bit         (round_bit),
        .sticky_bit        (sticky_bit),
        .sign_large        (sign_large),
        .sign_small        (sign_small),
        .swapped           (swapped)
    );

    always #5 clk = ~clk;

    assign obs = {exponent_out, significand_large, significand_small,
                  guard_bit, round_bit, sticky_bit, sign_large, sign_small, swapped};

    // Reference: shifts one bit at a time, folding whatever falls past round into sticky.
    function automatic logic [61:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, el;
        logic [23:0] sa, sb_sig, big, m;
        logic        g, r, s, sgl, sgs, sw;
        int          diff;
        ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        sa = {(a[30:23] != 8'd0), a[22:0]};
        sb_sig = {(b[30:23] != 8'd0), b[22:0]};
        if ({ea, a[22:0]} >= {eb, b[22:0]}) begin
            el = ea; big = sa; m = sb_sig; sgl = a[31]; sgs = b[31]; sw = 1'b0;
            diff = int'(ea) - int'(eb);
        end else begin
            el = eb; big = sb_sig; m = sa; sgl = b[31]; sgs = a[31]; sw = 1'b1;
            diff = int'(eb) - int'(ea);
        end
        g = 1'b0; r = 1'b0; s = 1'b0;
        for (int i = 0; i < diff; i++) begin
            s = s | r;
            r = g;
            g = m[0];
            m = m >> 1;
        end
        return {el, big, m, g, r, s, sgl, sgs, sw};
    endfunction

    task automatic checkOutput(input string tag, input logic [61:0] got, input logic [61:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic checkBit(input string tag, input logic got, input logic want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("[TB] FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Scoreboard: pop on output transfer first, then push on input accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                checkBit("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) checkOutput("sb_result", obs, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back(model(operand_a, operand_b));
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(posedge clk) #1;
        operand_a = a;
        operand_b = b;
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkBit("accept_timeout", in_ready, 1'b1);
        @(posedge clk) #1;
        in_valid = 1'b0;
    endtask

    task automatic runDirected(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [61:0] want);
        applyStimulus(a, b);
        checkBit({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk) #1;
        checkBit({tag, "_lat2"}, out_valid, 1'b1);
        checkOutput(tag, obs, want);
        @(posedge clk) #1;
    endtask

    localparam logic [61:0] P1_EXP = {8'h81, 24'hA00000, 24'h200000, 6'b000000};
    localparam logic [61:0] P2_EXP = {8'h82, 24'hA00000, 24'h200000, 6'b000000};
    localparam logic [61:0] P3_EXP = {8'h7E, 24'hC00000, 24'h800000, 6'b000001};
    localparam logic [61:0] BASIC  = {8'h80, 24'hC00000, 24'h400000, 6'b000000};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        operand_a = 32'd0;
        operand_b = 32'd0;
        #12;
        checkBit("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_outputs", obs, 62'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkBit("reset_in_ready", in_ready, 1'b1);

        runDirected("basic", 32'h40400000, 32'h3F800000, BASIC);
        runDirected("swap_sign", 32'h3F800000, 32'hC0400000,
                    {8'h80, 24'hC00000, 24'h400000, 6'b000101});
        runDirected("guard_sticky", 32'h4B800000, 32'h3F800001,
                    {8'h97, 24'h800000, 24'h000000, 6'b101000});
        runDirected("saturate", 32'h4F800000, 32'h3F800000,
                    {8'h9F, 24'h800000, 24'h000000, 6'b001000});
        runDirected("saturate_zero", 32'h4F800000, 32'h00000000,
                    {8'h9F, 24'h800000, 24'h000000, 6'b000000});

        // Backpressure: fill both stages, third pair must be refused.
        out_ready = 1'b0;
        applyStimulus(32'h40A00000, 32'h3F800000);
        applyStimulus(32'h41200000, 32'h40000000);
        operand_a = 32'h3F000000;
        operand_b = 32'h3F400000;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("full_in_ready", in_ready, 1'b0);
            checkBit("stall_out_valid", out_valid, 1'b1);
            checkOutput("stall_frozen", obs, P1_EXP);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        checkOutput("drain_p1", obs, P1_EXP);
        @(negedge clk);
        checkBit("drain_in_ready", in_ready, 1'b1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        checkBit("drain_p2_valid", out_valid, 1'b1);
        checkOutput("drain_p2", obs, P2_EXP);
        @(posedge clk) #1;
        checkBit("drain_p3_valid", out_valid, 1'b1);
        checkOutput("drain_p3", obs, P3_EXP);
        @(posedge clk) #1;
        checkBit("drain_empty", out_valid, 1'b0);

        // Reset with both stages full and output stalled.
        out_ready = 1'b0;
        applyStimulus(32'h40A00000, 32'h3F800000);
        applyStimulus(32'h41200000, 32'h40000000);
        checkBit("prereset_full", out_valid, 1'b1);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        checkBit("midreset_out_valid", out_valid, 1'b0);
        checkOutput("midreset_outputs", obs, 62'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checkBit("postreset_in_ready", in_ready, 1'b1);
        runDirected("post_reset", 32'h40400000, 32'h3F800000, BASIC);

        // Random stream with random bubbles and backpressure.
        for (int i = 0; i < 300; i++) begin
            @(posedge clk) #1;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb[30:23] = ra[30:23] - 8'($urandom_range(0, 30));
            if ($urandom_range(0, 7) == 0) rb[30:23] = 8'd0;
            operand_a = ra;
            operand_b = rb;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk) #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk) #1;
            n++;
        end
        checkBit("final_drain", sb.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
